// File: rtl/ext_input_conditioner.sv
// Conditions a raw asynchronous input: two-flop synchronizer, run-length debounce FSM,
// registered level/edge outputs and a saturating count of rejected transitions.
module ext_input_conditioner #(
    parameter int FILTER_CYCLES = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                CLK_IN,
    input  logic                RST_N_IN,
    input  logic                D16_i,
    input  logic                glitch_clr_i,
    output logic                level_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o,
    output logic [1:0]          dbg_state_o
);

    localparam int RUN_W = $clog2(FILTER_CYCLES);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } state_t;

    logic                r_sync1;
    logic                r_sync2;
    state_t              r_state;
    logic [RUN_W-1:0]    r_run;
    logic                r_level;
    logic                r_rise;
    logic                r_fall;
    logic [GLITCH_W-1:0] r_glitch_cnt;
    logic                w_s;
    logic                w_abort;

    assign w_s = r_sync2;

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= D16_i;
            r_sync2 <= r_sync1;
        end
    end

    // Level and edge pulses are updated on the same edge as the state move, so
    // rise_o/fall_o line up with the first cycle of the new level.
    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            r_state <= ST_LOW;
            r_run   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_LOW: begin
                    if (w_s) begin
                        r_state <= ST_CHK_HIGH;
                        r_run   <= RUN_W'(1);
                    end
                end
                ST_CHK_HIGH: begin
                    if (!w_s) begin
                        r_state <= ST_LOW;
                        r_run   <= '0;
                    end else if (r_run == RUN_LAST) begin
                        r_state <= ST_HIGH;
                        r_run   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_run <= r_run + RUN_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!w_s) begin
                        r_state <= ST_CHK_LOW;
                        r_run   <= RUN_W'(1);
                    end
                end
                ST_CHK_LOW: begin
                    if (w_s) begin
                        r_state <= ST_HIGH;
                        r_run   <= '0;
                    end else if (r_run == RUN_LAST) begin
                        r_state <= ST_LOW;
                        r_run   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_run <= r_run + RUN_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_LOW;
                    r_run   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign w_abort = ((r_state == ST_CHK_HIGH) && !w_s) ||
                     ((r_state == ST_CHK_LOW)  &&  w_s);

    // Clear takes priority over an abort landing on the same edge.
    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            r_glitch_cnt <= '0;
        end else if (glitch_clr_i) begin
            r_glitch_cnt <= '0;
        end else if (w_abort && (r_glitch_cnt != {GLITCH_W{1'b1}})) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
        end
    end

    assign level_o      = r_level;
    assign rise_o       = r_rise;
    assign fall_o       = r_fall;
    assign glitch_cnt_o = r_glitch_cnt;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_ext_input_conditioner.sv
// Directed bench for ext_input_conditioner: FILTER_CYCLES=4, GLITCH_W=2 so saturation is reachable.
module tb_ext_input_conditioner;

    localparam int FC = 4;
    localparam int GW = 2;

    logic          clk;
    logic          rst_n;
    logic          d_in;
    logic          glitch_clr;
    logic          level;
    logic          rise;
    logic          fall;
    logic [GW-1:0] glitch_cnt;
    logic [1:0]    dbg_state;

    int n_vec;
    int n_miss;
    int n_rise;
    int n_fall;
    int n_both;

    ext_input_conditioner #(.FILTER_CYCLES(FC), .GLITCH_W(GW)) dut (
        .CLK_IN       (clk),
        .RST_N_IN     (rst_n),
        .D16_i        (d_in),
        .glitch_clr_i (glitch_clr),
        .level_o      (level),
        .rise_o       (rise),
        .fall_o       (fall),
        .glitch_cnt_o (glitch_cnt),
        .dbg_state_o  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rise) n_rise++;
        if (fall) n_fall++;
        if (rise && fall) n_both++;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_glitch(input logic clr);
        d_in = 1'b1;
        tick();
        tick();
        d_in = 1'b0;
        tick();
        tick();
        glitch_clr = clr;
        tick();
        glitch_clr = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int exp_cnt;
        n_vec = 0; n_miss = 0; n_rise = 0; n_fall = 0; n_both = 0;
        rst_n = 1'b0; d_in = 1'b0; glitch_clr = 1'b0;
        #2;
        check_vec("reset_level", level, 0);
        check_vec("reset_rise", rise, 0);
        check_vec("reset_cnt", glitch_cnt, 0);
        check_vec("reset_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Async reset from a settled HIGH, asserted mid-cycle.
        d_in = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_vec("pre_async_level", level, 1);
        #2 rst_n = 1'b0;
        #1;
        check_vec("async_level", level, 0);
        check_vec("async_rise", rise, 0);
        check_vec("async_fall", fall, 0);
        check_vec("async_cnt", glitch_cnt, 0);
        check_vec("async_state", dbg_state, 0);
        d_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Rising edge: level changes after edge FC+2 with a single rise pulse.
        n_rise = 0; n_fall = 0;
        d_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_vec($sformatf("rise_level_e%0d", k), level, (k >= FC + 2) ? 1 : 0);
            check_vec($sformatf("rise_pulse_e%0d", k), rise, (k == FC + 2) ? 1 : 0);
        end
        check_vec("rise_count", n_rise, 1);
        check_vec("rise_cnt", glitch_cnt, 0);

        // Falling edge from HIGH.
        n_rise = 0; n_fall = 0;
        d_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_vec($sformatf("fall_level_e%0d", k), level, (k >= FC + 2) ? 0 : 1);
            check_vec($sformatf("fall_pulse_e%0d", k), fall, (k == FC + 2) ? 1 : 0);
        end
        check_vec("fall_count", n_fall, 1);
        check_vec("fall_no_rise", n_rise, 0);

        // Short pulse is rejected and counted.
        n_rise = 0; n_fall = 0;
        do_glitch(1'b0);
        check_vec("glitch_level", level, 0);
        check_vec("glitch_no_rise", n_rise, 0);
        check_vec("glitch_cnt1", glitch_cnt, 1);

        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        check_vec("clr_cnt", glitch_cnt, 0);

        // Saturation at 2^GW-1, then clear coincident with another abort.
        for (int g = 1; g <= 5; g++) begin
            do_glitch(1'b0);
            exp_cnt = (g > 3) ? 3 : g;
            check_vec($sformatf("sat_cnt_g%0d", g), glitch_cnt, exp_cnt);
        end
        do_glitch(1'b1);
        check_vec("clr_vs_abort", glitch_cnt, 0);
        check_vec("sat_level", level, 0);
        check_vec("sat_no_edges", n_rise + n_fall, 0);

        // Reset while in CHK_HIGH with run=3 discards the partial run.
        d_in = 1'b1;
        for (int i = 0; i < FC + 1; i++) tick();
        check_vec("midchk_state", dbg_state, 1);
        check_vec("midchk_run", dut.r_run, 3);
        rst_n = 1'b0;
        #2;
        check_vec("midchk_rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_rise = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_vec($sformatf("midchk_level_e%0d", k), level, (k >= FC + 2) ? 1 : 0);
            check_vec($sformatf("midchk_rise_e%0d", k), rise, (k == FC + 2) ? 1 : 0);
        end
        check_vec("midchk_rise_count", n_rise, 1);
        check_vec("never_both", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
